bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/calc_pkg.sv | 14 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin2bcd_seq.sv | 77 +++++++
 tb/tb_bin2bcd_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned ADD3_MIN = 5;
  localparam int unsigned ADD3_VAL = 3;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before it doubles.
module bcd_add3
  import calc_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= DIGIT_W'(ADD3_MIN)) ? digit + DIGIT_W'(ADD3_VAL) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, three BCD digits out.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        bin,
  output logic                busy,
  output logic                done,
  output logic [DIGIT_W-1:0]  hundreds,
  output logic [DIGIT_W-1:0]  tens,
  output logic [DIGIT_W-1:0]  ones
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [W-1:0]         sr;
  logic [DIGIT_W-1:0]   s_h, s_t, s_o;
  logic [DIGIT_W-1:0]   a_h, a_t, a_o;

  bcd_add3 u_add3_h (.digit(s_h), .adjusted(a_h));
  bcd_add3 u_add3_t (.digit(s_t), .adjusted(a_t));
  bcd_add3 u_add3_o (.digit(s_o), .adjusted(a_o));

  // Scratch digits stay private; the visible digits update only when a conversion finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      s_h      <= '0;
      s_t      <= '0;
      s_o      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= bin;
            s_h   <= '0;
            s_t   <= '0;
            s_o   <= '0;
            cnt   <= CNT_W'(W);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // The hundreds carry-out is dropped; legal widths never exceed 999.
          {s_h, s_t, s_o, sr} <= {a_h[DIGIT_W-2:0], a_t, a_o, sr, 1'b0};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FINISH;
        end
        FINISH: begin
          hundreds <= s_h;
          tens     <= s_t;
          ones     <= s_o;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized and directed checks of bin2bcd_seq against a latency/arithmetic model.
module tb_bin2bcd_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] bin = '0;
  logic busy, done;
  logic [3:0] hundreds, tens, ones;

  logic start9 = 1'b0;
  logic [8:0] bin9 = '0;
  logic busy9, done9;
  logic [3:0] hundreds9, tens9, ones9;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .hundreds(hundreds), .tens(tens), .ones(ones)
  );

  bin2bcd_seq #(.W(9)) dut9 (
    .clk(clk), .rst(rst), .start(start9), .bin(bin9),
    .busy(busy9), .done(done9), .hundreds(hundreds9), .tens(tens9), .ones(ones9)
  );

  function automatic logic [11:0] conv(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a conversion occupies W+1 edges after acceptance, then shows value/100 etc.
  int          m_remain;
  int          m_val;
  logic        m_busy, m_done;
  logic [11:0] m_digits;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_remain <= 0;
      m_val    <= 0;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_digits <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_remain == 0) begin
        if (start) begin
          m_val    <= int'(bin);
          m_remain <= W + 1;
          m_busy   <= 1'b1;
        end
      end else begin
        m_remain <= m_remain - 1;
        if (m_remain == 1) begin
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          m_digits <= conv(m_val);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("hundreds", int'(hundreds), int'(m_digits[11:8]));
    chk("tens", int'(tens), int'(m_digits[7:4]));
    chk("ones", int'(ones), int'(m_digits[3:0]));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Launch one conversion, scramble bin afterwards, and count edges until done.
  task automatic run_conv(input int v, output int lat);
    int n = 0;
    wait_idle();
    start = 1'b1;
    bin   = W'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = W'($urandom);
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    lat = n;
  endtask

  task automatic run_lit(input string name, input int v, input int h, input int t, input int o);
    int lat;
    run_conv(v, lat);
    chk({name, "_lat"}, lat, 9);
    chk({name, "_h"}, int'(hundreds), h);
    chk({name, "_t"}, int'(tens), t);
    chk({name, "_o"}, int'(ones), o);
    #1;
  endtask

  initial begin
    int lat;
    int n;
    int seen;
    repeat (2) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_digits", int'({hundreds, tens, ones}), 0);
    rst = 1'b0;

    // Zero, extremes and round values.
    run_lit("bin0", 0, 0, 0, 0);
    run_lit("bin255", 255, 2, 5, 5);
    run_lit("bin7", 7, 0, 0, 7);
    run_lit("bin100", 100, 1, 0, 0);

    // Second start while busy is ignored.
    wait_idle();
    start = 1'b1; bin = 8'd42;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; bin = 8'd99;
    tick();
    start = 1'b0; bin = 8'd7;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    chk("ignore_lat", n + 3, 9);
    chk("ignore_res", int'({hundreds, tens, ones}), 12'h042);
    tick();
    chk("ignore_no_second", int'(busy), 0);

    // Reset mid-conversion aborts it; next start right after release works.
    wait_idle();
    start = 1'b1; bin = 8'd200;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    seen = 0;
    repeat (3) begin tick(); if (done) seen++; end
    rst = 1'b0;
    repeat (10) begin tick(); if (done) seen++; end
    chk("abort_no_done", seen, 0);
    chk("abort_digits", int'({hundreds, tens, ones}), 0);
    start = 1'b1; bin = 8'd13;
    @(posedge clk); #1;
    chk("post_reset_accept", int'(busy), 1);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("post_reset_lat", n, 9);
    chk("post_reset_res", int'({hundreds, tens, ones}), 12'h013);
    #1;

    // Back-to-back: start on the done cycle.
    run_conv(128, lat);
    chk("b2b_first", int'({hundreds, tens, ones}), 12'h128);
    start = 1'b1; bin = 8'd64;
    n = 0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_gap", n, 10);
    chk("b2b_res", int'({hundreds, tens, ones}), 12'h064);
    #1;

    // Full sweep against the model.
    for (int v = 0; v < 256; v++) begin
      run_conv(v, lat);
      chk("sweep_lat", lat, 9);
      chk("sweep_res", int'({hundreds, tens, ones}), int'(conv(v)));
      #1;
    end

    // Held-high start relaunches every idle cycle.
    start = 1'b1;
    repeat (40) begin bin = W'($urandom); tick(); end
    start = 1'b0;

    // Random start pulses, bin noise and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 2) == 0);
      bin   = W'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (12) tick();

    // Nine-bit build: 511 -> 5/1/1, done 10 edges after start.
    start9 = 1'b1; bin9 = 9'd511;
    @(posedge clk); #1;
    start9 = 1'b0; bin9 = 9'd3;
    n = 0;
    while (!done9 && n < 40) begin @(posedge clk); #1; n++; end
    chk("w9_lat", n, 10);
    chk("w9_res", int'({hundreds9, tens9, ones9}), 12'h511);
    tick();
    chk("w9_done_pulse", int'(done9), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
